// File: rtl/lca_pkg.sv
// Shared lookahead-carry package: default width and the carry-chain helper
// used by the subtractor and the adder variants.
package lca_pkg;

    localparam int LCA_WIDTH_DEFAULT = 8;
    // Widest operand the carry helper supports; callers zero-extend p/g.
    localparam int LCA_MAX_WIDTH     = 64;

    // Carry vector c[0..LCA_MAX_WIDTH]: c[i+1] = g[i] | (p[i] & c[i]).
    // Zero-extended p/g bits yield zero carries above the caller's width.
    function automatic logic [LCA_MAX_WIDTH:0] lca_carries(
        input logic [LCA_MAX_WIDTH-1:0] p,
        input logic [LCA_MAX_WIDTH-1:0] g,
        input logic                     c0
    );
        logic [LCA_MAX_WIDTH:0] c;
        c[0] = c0;
        for (int i = 0; i < LCA_MAX_WIDTH; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/lca_pg_unit.sv
// Propagate/generate terms for a - b: the subtrahend is inverted so the
// adder lookahead computes a + ~b + ~bin.
module lca_pg_unit
    import lca_pkg::*;
#(
    parameter int WIDTH = LCA_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p,
    output logic [WIDTH-1:0] o_g
);

    logic [WIDTH-1:0] w_bb;

    assign w_bb = ~i_b;
    assign o_p  = i_a ^ w_bb;
    assign o_g  = i_a & w_bb;

endmodule

// File: rtl/lca_subtractor_pipe.sv
// Two-stage lookahead-borrow subtractor with valid/ready on both sides.
// S1 holds p/g/c0, S2 holds diff/bout. Optional signed overflow output is
// enabled by defining LCA_SUB_OVF_EN.
module lca_subtractor_pipe
    import lca_pkg::*;
#(
    parameter int WIDTH = LCA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef LCA_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0]       w_p, w_g;
    logic                   w_s1_en, w_s2_en;

    logic                   r_s1_valid;
    logic [WIDTH-1:0]       r_p, r_g;
    logic                   r_c0;

    logic [LCA_MAX_WIDTH-1:0] w_p_ext, w_g_ext;
    logic [LCA_MAX_WIDTH:0]   w_c_all;
    logic [WIDTH:0]           w_c;
    logic                     w_unused_hi;
    logic [WIDTH-1:0]         w_diff;
    logic                     w_bout;

    logic                   r_out_valid;
    logic [WIDTH-1:0]       r_diff;
    logic                   r_bout;

`ifdef LCA_SUB_OVF_EN
    logic                   r_a_msb, r_b_msb;
    logic                   w_ovf;
    logic                   r_ovf;
`endif

    // S2 drains whenever it is empty or the consumer takes it; S1 moves when S2 can.
    assign w_s2_en  = !r_out_valid || out_ready;
    assign w_s1_en  = !r_s1_valid || w_s2_en;
    assign in_ready = w_s1_en && !rst;

    lca_pg_unit #(.WIDTH(WIDTH)) u_pg (
        .i_a (a),
        .i_b (b),
        .o_p (w_p),
        .o_g (w_g)
    );

    // S1: capture propagate/generate and the inverted borrow-in on input transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_p        <= '0;
            r_g        <= '0;
            r_c0       <= 1'b0;
`ifdef LCA_SUB_OVF_EN
            r_a_msb    <= 1'b0;
            r_b_msb    <= 1'b0;
`endif
        end else if (w_s1_en) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_p  <= w_p;
                r_g  <= w_g;
                r_c0 <= ~bin;
`ifdef LCA_SUB_OVF_EN
                r_a_msb <= a[WIDTH-1];
                r_b_msb <= b[WIDTH-1];
`endif
            end
        end
    end

    // Lookahead carries from S1 state; upper helper bits beyond WIDTH are don't-care
    always_comb begin
        w_p_ext              = '0;
        w_g_ext              = '0;
        w_p_ext[WIDTH-1:0]   = r_p;
        w_g_ext[WIDTH-1:0]   = r_g;
        w_c_all              = lca_carries(w_p_ext, w_g_ext, r_c0);
    end

    assign w_c         = w_c_all[WIDTH:0];
    assign w_unused_hi = ^w_c_all;
    assign w_diff      = r_p ^ w_c[WIDTH-1:0];
    assign w_bout      = ~w_c[WIDTH];

`ifdef LCA_SUB_OVF_EN
    assign w_ovf = (r_a_msb != r_b_msb) && (w_diff[WIDTH-1] != r_a_msb);
`endif

    // S2: result register, held stable while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
`ifdef LCA_SUB_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else if (w_s2_en) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_diff <= w_diff;
                r_bout <= w_bout;
`ifdef LCA_SUB_OVF_EN
                r_ovf  <= w_ovf;
`endif
            end
        end
    end

    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
`ifdef LCA_SUB_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_lca_subtractor_pipe.sv
// Directed + random bench for lca_subtractor_pipe with an expected-result queue.
// Define LCA_SUB_OVF_EN to also exercise the overflow output.
module tb_lca_subtractor_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
`ifdef LCA_SUB_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    lca_subtractor_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef LCA_SUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         o;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_out    = 0;
    int   n_acc    = 0;
    logic last_in_ready;
    logic fix_en = 1'b0;
    exp_t fix_e;

    function automatic exp_t model(logic [W-1:0] a_, logic [W-1:0] b_, logic bin_);
        exp_t     m;
        logic [W:0] r;
        r   = {1'b0, a_} - {1'b0, b_} - {{W{1'b0}}, bin_};
        m.d = r[W-1:0];
        m.b = r[W];
        m.o = (a_[W-1] != b_[W-1]) && (r[W-1] != a_[W-1]);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: observe handshakes at negedge, then step past the next rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_in_ready = in_ready;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL unexpected_out observed diff=%0h expected no output", diff);
            end else begin
                e = q.pop_front();
                chk("diff", 32'(diff), 32'(e.d));
                chk("bout", 32'(bout), 32'(e.b));
`ifdef LCA_SUB_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.o));
`endif
            end
            n_out++;
        end
        if (in_valid && in_ready) begin
            q.push_back(fix_en ? fix_e : model(a, b, bin));
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 20 && q.size() > 0; i++) cycle();
        if (q.size() > 0) begin
            checks++;
            failures++;
            $error("FAIL %s_timeout observed pending=%0d expected 0", tag, q.size());
            q.delete();
        end
    endtask

    // Directed op with a hand-written expectation.
    task automatic one_op(input logic [W-1:0] a_, input logic [W-1:0] b_, input logic bin_,
                          input logic [W-1:0] d_, input logic bo_, input logic o_);
        a = a_; b = b_; bin = bin_; in_valid = 1'b1;
        fix_e.d = d_; fix_e.b = bo_; fix_e.o = o_;
        fix_en = 1'b1;
        cycle();
        fix_en = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] held;
        int base_acc, base_out, stall_cnt;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        cycle(); cycle();
        // reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef LCA_SUB_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // 1: basic op and two-cycle latency
        one_op(8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        chk("lat_1cyc_out_valid", 32'(out_valid), 32'd0);
        cycle();
        chk("lat_2cyc_out_valid", 32'(out_valid), 32'd1);
        drain("t1");

        // 2: borrow cases and boundaries
        one_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        one_op(8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
        one_op(8'hA5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
        one_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0);
        drain("t2");

        // 3: 256 random back-to-back vectors
        base_out = n_out;
        stall_cnt = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            cycle();
            if (!last_in_ready) stall_cnt++;
        end
        in_valid = 1'b0;
        chk("stream_stalls", 32'(stall_cnt), 32'd0);
        chk("stream_outs_inflight", 32'(n_out - base_out), 32'd254);
        drain("t3");
        chk("stream_outs_total", 32'(n_out - base_out), 32'd256);

        // 4: backpressure
        out_ready = 1'b0;
        base_acc = n_acc;
        base_out = n_out;
        in_valid = 1'b1;
        a = 8'h33; b = 8'h11; bin = 1'b0; cycle();
        a = 8'h10; b = 8'h20; bin = 1'b1; cycle();
        a = 8'h7E; b = 8'h3C; bin = 1'b1; cycle();
        chk("stall_accepted", 32'(n_acc - base_acc), 32'd2);
        chk("stall_in_ready", 32'(last_in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        held = diff;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_diff_stable", 32'(diff), 32'(held));
        chk("stall_diff_value", 32'(diff), 32'h22);
        chk("stall_in_ready_hold", 32'(last_in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && (n_acc - base_acc) < 3; i++) cycle();
        in_valid = 1'b0;
        chk("stall_accepted_all", 32'(n_acc - base_acc), 32'd3);
        drain("t4");
        chk("stall_outs", 32'(n_out - base_out), 32'd3);

        // 5: reset with two ops in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        a = 8'h99; b = 8'h11; bin = 1'b0; cycle();
        a = 8'h44; b = 8'h22; bin = 1'b0; cycle();
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        q.delete();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_diff", 32'(diff), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        base_out = n_out;
        for (int i = 0; i < 4; i++) cycle();
        chk("midrst_no_stale", 32'(n_out - base_out), 32'd0);
        one_op(8'h0C, 8'h03, 1'b1, 8'h08, 1'b0, 1'b0);
        drain("t5");
        chk("midrst_new_out", 32'(n_out - base_out), 32'd1);

`ifdef LCA_SUB_OVF_EN
        // 6: signed overflow
        one_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        one_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        one_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
        drain("t6");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
